// File: rtl/if_flow_pkg.sv
// Shared types and constants for the IF-stage flow controller and its hazard helper.
package if_flow_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    IM_WAIT  = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam int          CNT_W    = 3;

  // Saturating increment for the optional statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/if_flow_ctrl_if.sv
// PC-register / pipeline-control bundle; master = flow controller, slave = datapath side.
interface if_flow_ctrl_if;
  logic [31:0] IM_Addr;
  logic        im_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_mem_read;
  logic [4:0]  id_ex_rd;
  logic [4:0]  if_id_rs;
  logic [4:0]  if_id_rt;
  logic        PC_Write;
  logic [31:0] IM_Addr_nx;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Bubble;

  modport master (
    input  IM_Addr, im_ready, br_taken, br_target,
    input  id_mem_read, id_ex_rd, if_id_rs, if_id_rt,
    output PC_Write, IM_Addr_nx, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble
  );

  modport slave (
    output IM_Addr, im_ready, br_taken, br_target,
    output id_mem_read, id_ex_rd, if_id_rs, if_id_rt,
    input  PC_Write, IM_Addr_nx, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble
  );
endinterface

// File: rtl/lu_hazard_detect.sv
// Combinational load-use compare: a load in ID/EX writing a register read by IF/ID.
module lu_hazard_detect
  import if_flow_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       hazard
);

  assign hazard = mem_read && (ex_rd != REG_ZERO) && ((ex_rd == rs) || (ex_rd == rt));

endmodule

// File: rtl/if_flow_ctrl.sv
// Next-PC and IF-stage flow controller: redirects, load-use stalls and imem wait states.
// Optional statistics outputs are enabled with `define IF_FLOW_STATS_EN.
module if_flow_ctrl
  import if_flow_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FLUSH_CYCLES    = 1,
  parameter int          LU_STALL_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  if_flow_ctrl_if.master bus
`ifdef IF_FLOW_STATS_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    redirect_count
`endif
);

  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LU_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pend, pend_nx;
  logic [31:0]      pend_tgt, pend_tgt_nx;

  logic        lu;
  logic        redirect_req;
  logic [31:0] redirect_tgt;
  logic [31:0] pc_seq;

  logic        pc_write;
  logic        if_id_write;
  logic        flush;
  logic        bubble;
  logic [31:0] addr_nx;

  lu_hazard_detect u_lu (
    .mem_read (bus.id_mem_read),
    .ex_rd    (bus.id_ex_rd),
    .rs       (bus.if_id_rs),
    .rt       (bus.if_id_rt),
    .hazard   (lu)
  );

  // A redirect latched during an imem wait behaves like a fresh branch once memory is ready.
  assign redirect_req = bus.br_taken || ((state == IM_WAIT) && pend);
  assign redirect_tgt = bus.br_taken ? bus.br_target : pend_tgt;
  assign pc_seq       = bus.IM_Addr + PC_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      pend     <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pend     <= pend_nx;
      pend_tgt <= pend_tgt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pend_nx     = pend;
    pend_tgt_nx = pend_tgt;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    flush       = 1'b0;
    bubble      = 1'b0;
    addr_nx     = pc_seq;

    if (redirect_req) begin
      flush  = 1'b1;
      bubble = 1'b1;
      if (bus.im_ready) begin
        addr_nx  = redirect_tgt;
        pend_nx  = 1'b0;
        cnt_nx   = FLUSH_RELOAD;
        state_nx = (FLUSH_CYCLES > 1) ? REDIRECT : RUN;
      end else begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pend_nx     = 1'b1;
        pend_tgt_nx = redirect_tgt;
        state_nx    = IM_WAIT;
      end
    end else if (state == REDIRECT) begin
      // The squashed IF/ID slot makes any load-use compare here meaningless.
      flush       = 1'b1;
      bubble      = 1'b1;
      pc_write    = bus.im_ready;
      if_id_write = bus.im_ready;
      cnt_nx      = cnt - CNT_ONE;
      if (cnt <= CNT_ONE) state_nx = RUN;
    end else if (state == LU_STALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
      cnt_nx      = cnt - CNT_ONE;
      if (cnt <= CNT_ONE) state_nx = RUN;
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
      cnt_nx      = LU_RELOAD;
      state_nx    = (LU_STALL_CYCLES > 1) ? LU_STALL : RUN;
    end else if (!bus.im_ready) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      bubble      = 1'b1;
      state_nx    = IM_WAIT;
    end else begin
      state_nx    = RUN;
    end

    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      flush       = 1'b0;
      bubble      = 1'b1;
      addr_nx     = RESET_PC;
    end
  end

  assign bus.PC_Write     = pc_write;
  assign bus.IM_Addr_nx   = addr_nx;
  assign bus.IF_ID_Write  = if_id_write;
  assign bus.IF_ID_Flush  = flush;
  assign bus.ID_EX_Bubble = bubble;

`ifdef IF_FLOW_STATS_EN
  logic redirect_applied;

  // Flush with a PC update outside REDIRECT, or a restart inside it, is a newly applied target.
  assign redirect_applied = flush && pc_write && ((state != REDIRECT) || bus.br_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (!pc_write)        stall_cycles   <= sat_inc(stall_cycles);
      if (redirect_applied) redirect_count <= sat_inc(redirect_count);
    end
  end
`endif

endmodule

// File: tb/tb_if_flow_ctrl.sv
// Testbench for if_flow_ctrl: directed vector table, pending-redirect sequence, randomized model check.
module tb_if_flow_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam int          FC     = 2;
  localparam int          LC     = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_flow_ctrl_if bus();

`ifdef IF_FLOW_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] redirect_count;
`endif

  if_flow_ctrl #(
    .RESET_PC        (RST_PC),
    .FLUSH_CYCLES    (FC),
    .LU_STALL_CYCLES (LC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus)
`ifdef IF_FLOW_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .redirect_count (redirect_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic [31:0] addr;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic [31:0] nx;
    logic        chk_nx;
  } vec_t;

  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: remaining flush/stall cycles, waiting flag and latest pending target.
  int          m_flush_left, m_stall_left;
  bit          m_wait, m_pend;
  logic [31:0] m_pend_tgt, m_pc;
  int          m_stalls, m_redirs;
  int          n_flush_left, n_stall_left;
  bit          n_wait, n_pend;
  logic [31:0] n_pend_tgt;
  logic        e_pcw, e_ifw, e_fl, e_bub, e_applied;
  logic [31:0] e_nx;

  function automatic vec_t mkVec(input logic r, input logic [31:0] addr, input logic rdy,
                                 input logic br, input logic [31:0] tgt, input logic mr,
                                 input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic pcw, input logic ifw, input logic fl, input logic bub,
                                 input logic [31:0] nx, input logic chk);
    vec_t v;
    v.rst = r; v.addr = addr; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.mr = mr; v.rd = rd; v.rs = rs; v.rt = rt;
    v.pcw = pcw; v.ifw = ifw; v.fl = fl; v.bub = bub; v.nx = nx; v.chk_nx = chk;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst             = v.rst;
    bus.IM_Addr     = v.addr;
    bus.im_ready    = v.rdy;
    bus.br_taken    = v.br;
    bus.br_target   = v.tgt;
    bus.id_mem_read = v.mr;
    bus.id_ex_rd    = v.rd;
    bus.if_id_rs    = v.rs;
    bus.if_id_rt    = v.rt;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic pcw, input logic ifw, input logic fl,
                             input logic bub, input logic [31:0] nx, input logic chk_nx);
    bit bad;
    vectors++;
    bad = (bus.PC_Write !== pcw) || (bus.IF_ID_Write !== ifw) ||
          (bus.IF_ID_Flush !== fl) || (bus.ID_EX_Bubble !== bub) ||
          (chk_nx && (bus.IM_Addr_nx !== nx));
    if (bad) begin
      miscompares++;
      $display("[TB] FAIL %s: got pcw=%b ifw=%b flush=%b bubble=%b nx=%h, want pcw=%b ifw=%b flush=%b bubble=%b nx=%h",
               name, bus.PC_Write, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Bubble, bus.IM_Addr_nx,
               pcw, ifw, fl, bub, chk_nx ? nx : bus.IM_Addr_nx);
    end
  endtask

  task automatic runVec(input string name, input vec_t v);
    applyStimulus(v);
    checkOutput(name, v.pcw, v.ifw, v.fl, v.bub, v.nx, v.chk_nx);
  endtask

  // Behavioural reference: computes expected outputs and the next model state from the current inputs.
  task automatic modelEval();
    bit          is_lu;
    bit          want;
    logic [31:0] tgt;
    is_lu = bus.id_mem_read && (bus.id_ex_rd != 5'd0) &&
            (bus.id_ex_rd == bus.if_id_rs || bus.id_ex_rd == bus.if_id_rt);
    want  = bus.br_taken || (m_wait && m_pend);
    tgt   = bus.br_taken ? bus.br_target : m_pend_tgt;
    n_flush_left = m_flush_left; n_stall_left = m_stall_left;
    n_wait = m_wait; n_pend = m_pend; n_pend_tgt = m_pend_tgt;
    e_pcw = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_nx = bus.IM_Addr + 32'd4; e_applied = 0;
    if (rst) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1; e_nx = RST_PC;
      n_flush_left = 0; n_stall_left = 0; n_wait = 0; n_pend = 0;
    end else if (want) begin
      e_fl = 1; e_bub = 1; n_stall_left = 0;
      if (bus.im_ready) begin
        e_nx = tgt; e_applied = 1;
        n_flush_left = FC - 1; n_pend = 0; n_wait = 0;
      end else begin
        e_pcw = 0; e_ifw = 0;
        n_flush_left = 0; n_pend = 1; n_pend_tgt = tgt; n_wait = 1;
      end
    end else if (m_flush_left > 0) begin
      e_fl = 1; e_bub = 1; e_pcw = bus.im_ready; e_ifw = bus.im_ready;
      n_flush_left = m_flush_left - 1;
    end else if (m_stall_left > 0) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1;
      n_stall_left = m_stall_left - 1;
    end else if (is_lu) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1;
      n_stall_left = LC - 1; n_wait = 0;
    end else if (!bus.im_ready) begin
      e_pcw = 0; e_ifw = 0; e_bub = 1; n_wait = 1;
    end else begin
      n_wait = 0;
    end
  endtask

  task automatic modelCommit();
    if (rst) begin
      m_stalls = 0; m_redirs = 0; m_pc = RST_PC;
    end else begin
      if (!e_pcw) m_stalls++;
      if (e_applied) m_redirs++;
      if (e_pcw) m_pc = e_nx;
    end
    m_flush_left = n_flush_left; m_stall_left = n_stall_left;
    m_wait = n_wait; m_pend = n_pend; m_pend_tgt = n_pend_tgt;
  endtask

  initial begin
    rst = 1'b1;
    bus.IM_Addr = '0; bus.im_ready = 1'b1; bus.br_taken = 1'b0; bus.br_target = '0;
    bus.id_mem_read = 1'b0; bus.id_ex_rd = '0; bus.if_id_rs = '0; bus.if_id_rt = '0;

    //                 rst addr           rdy br tgt          mr rd rs rt  pcw ifw fl bub nx            chk
    tbl.push_back(mkVec(1, 32'h0,          1, 0, 32'h0,       0, 0, 0, 0,  0,  0,  0, 1, RST_PC,       1));
    tbl.push_back(mkVec(0, 32'h0,          1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h4,        1));
    tbl.push_back(mkVec(0, 32'h4,          1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h8,        1));
    tbl.push_back(mkVec(0, 32'h8,          1, 0, 32'h0,       1, 5, 1, 5,  0,  0,  0, 1, 32'h0,        0));
    tbl.push_back(mkVec(0, 32'h8,          1, 0, 32'h0,       1, 5, 1, 5,  0,  0,  0, 1, 32'h0,        0));
    tbl.push_back(mkVec(0, 32'h8,          1, 0, 32'h0,       1, 5, 1, 5,  0,  0,  0, 1, 32'h0,        0));
    tbl.push_back(mkVec(0, 32'h8,          1, 0, 32'h0,       0, 5, 1, 5,  1,  1,  0, 0, 32'hC,        1));
    tbl.push_back(mkVec(0, 32'hC,          1, 0, 32'h0,       1, 0, 0, 0,  1,  1,  0, 0, 32'h10,       1));
    tbl.push_back(mkVec(0, 32'h10,         1, 1, 32'h100,     0, 0, 0, 0,  1,  1,  1, 1, 32'h100,      1));
    tbl.push_back(mkVec(0, 32'h100,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  1, 1, 32'h104,      1));
    tbl.push_back(mkVec(0, 32'h104,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h108,      1));
    tbl.push_back(mkVec(0, 32'h108,        1, 1, 32'h300,     1, 7, 7, 0,  1,  1,  1, 1, 32'h300,      1));
    tbl.push_back(mkVec(0, 32'h300,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  1, 1, 32'h304,      1));
    tbl.push_back(mkVec(0, 32'h304,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h308,      1));
    tbl.push_back(mkVec(0, 32'hFFFF_FFFC,  1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h0,        1));
    tbl.push_back(mkVec(0, 32'h0,          0, 0, 32'h0,       0, 0, 0, 0,  0,  0,  0, 1, 32'h0,        0));
    tbl.push_back(mkVec(0, 32'h0,          0, 0, 32'h0,       0, 0, 0, 0,  0,  0,  0, 1, 32'h0,        0));
    tbl.push_back(mkVec(0, 32'h0,          1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h4,        1));
    tbl.push_back(mkVec(0, 32'h600,        1, 1, 32'h600,     0, 0, 0, 0,  1,  1,  1, 1, 32'h600,      1));
    tbl.push_back(mkVec(0, 32'h600,        1, 1, 32'h700,     0, 0, 0, 0,  1,  1,  1, 1, 32'h700,      1));
    tbl.push_back(mkVec(0, 32'h700,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  1, 1, 32'h704,      1));
    tbl.push_back(mkVec(0, 32'h704,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h708,      1));
    tbl.push_back(mkVec(0, 32'h708,        1, 0, 32'h0,       1, 3, 3, 9,  0,  0,  0, 1, 32'h0,        0));
    tbl.push_back(mkVec(0, 32'h708,        1, 1, 32'h900,     1, 3, 3, 9,  1,  1,  1, 1, 32'h900,      1));
    tbl.push_back(mkVec(0, 32'h900,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  1, 1, 32'h904,      1));
    tbl.push_back(mkVec(0, 32'h904,        1, 0, 32'h0,       0, 0, 0, 0,  1,  1,  0, 0, 32'h908,      1));
    tbl.push_back(mkVec(1, 32'h904,        1, 0, 32'h0,       0, 0, 0, 0,  0,  0,  0, 1, RST_PC,       1));

    foreach (tbl[i]) runVec($sformatf("table[%0d]", i), tbl[i]);

    // Pending redirect: latest target taken while imem stalls, applied once ready.
    runVec("pend_wait0",   mkVec(0, 32'h20, 0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 0, 1, 32'h0,  0));
    runVec("pend_br40",    mkVec(0, 32'h20, 0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0,  0));
    runVec("pend_br80",    mkVec(0, 32'h20, 0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0,  0));
    runVec("pend_apply",   mkVec(0, 32'h20, 1, 0, 32'h0,  0, 0, 0, 0, 1, 1, 1, 1, 32'h80, 1));
    runVec("pend_flush2",  mkVec(0, 32'h80, 1, 0, 32'h0,  0, 0, 0, 0, 1, 1, 1, 1, 32'h84, 1));
    runVec("pend_resume",  mkVec(0, 32'h84, 1, 0, 32'h0,  0, 0, 0, 0, 1, 1, 0, 0, 32'h88, 1));

    // Reset while a redirect is pending must discard it.
    runVec("rstpend_br",   mkVec(0, 32'h88,  0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0,   0));
    runVec("rstpend_rst",  mkVec(1, 32'h88,  0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 0, 1, RST_PC,  1));
    runVec("rstpend_run",  mkVec(0, RST_PC,  1, 0, 32'h0,   0, 0, 0, 0, 1, 1, 0, 0, 32'h204, 1));

    // Randomized phase against the reference model.
    applyStimulus(mkVec(1, 32'h0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1, RST_PC, 1));
    m_flush_left = 0; m_stall_left = 0; m_wait = 0; m_pend = 0; m_pend_tgt = '0;
    m_pc = RST_PC; m_stalls = 0; m_redirs = 0;
    @(posedge clk);
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) m_pc = 32'hFFFF_FFFC;
      rst             = ($urandom_range(0, 99) == 0);
      bus.IM_Addr     = m_pc;
      bus.im_ready    = ($urandom_range(0, 3) != 0);
      bus.br_taken    = ($urandom_range(0, 9) == 0);
      bus.br_target   = {$urandom_range(0, 32'h3FFF), 2'b00};
      bus.id_mem_read = ($urandom_range(0, 2) == 0);
      bus.id_ex_rd    = 5'($urandom_range(0, 3));
      bus.if_id_rs    = 5'($urandom_range(0, 3));
      bus.if_id_rt    = 5'($urandom_range(0, 3));
      #1;
      modelEval();
      checkOutput("random", e_pcw, e_ifw, e_fl, e_bub, e_nx, e_pcw | rst);
      @(posedge clk);
      modelCommit();
    end

`ifdef IF_FLOW_STATS_EN
    @(negedge clk);
    vectors++;
    if (stall_cycles !== 32'(m_stalls) || redirect_count !== 32'(m_redirs)) begin
      miscompares++;
      $display("[TB] FAIL stats: got stall=%0d redir=%0d, want stall=%0d redir=%0d",
               stall_cycles, redirect_count, m_stalls, m_redirs);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
